// File: rtl/truth_table_sequencer.sv
// Stimulus-and-check stage for a 3-input combinational block: walks {x,y,z}
// through 0..7, samples a after a settle time and scores it against EXPECT_TT.
module truth_table_sequencer #(
  parameter int unsigned HOLD      = 2,
  parameter logic [7:0]  EXPECT_TT = 8'h26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       a,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  logic [1:0] state;
  logic [2:0] vec;
  logic [3:0] hold_cnt;
  logic [3:0] err_next;
  logic [7:0] map_next;

  // Score of the vector currently on {x,y,z}; only committed in SAMPLE.
  always_comb begin
    err_next = err_count;
    map_next = fail_map;
    if (a != EXPECT_TT[vec]) begin
      err_next      = err_count + 4'd1;
      map_next[vec] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec       <= '0;
      hold_cnt  <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      z         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_map  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            vec       <= '0;
            hold_cnt  <= '0;
            {x, y, z} <= 3'b000;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_map  <= '0;
          end
        end
        S_DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_SAMPLE;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          err_count <= err_next;
          fail_map  <= map_next;
          if (vec == 3'd7) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_next == 4'd0);
            {x, y, z} <= 3'b000;
          end else begin
            state     <= S_DRIVE;
            vec       <= vec + 3'd1;
            hold_cnt  <= '0;
            {x, y, z} <= vec + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: stimulus queues expected {x,y,z} per busy cycle and the
// expected sweep result; per-DUT monitors pop and compare independently.
module tb_truth_table_sequencer;

  localparam int MODE_GOLD = 0;
  localparam int MODE_ZERO = 1;
  localparam int MODE_ONE  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         done_edge;
    logic       pass;
    logic [3:0] err;
    logic [7:0] map;
  } res_t;

  res_t       res_q0[$], res_q1[$];
  logic [2:0] xyz_q0[$], xyz_q1[$];

  // DUT0: HOLD=2, DUT1: HOLD=1, both default truth table
  logic start0 = 1'b0, start1 = 1'b0;
  logic a0, a1, x0, y0, z0, x1, y1, z1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [7:0] map0, map1;
  int mode0 = MODE_GOLD, mode1 = MODE_GOLD;

  always_comb begin
    case (mode0)
      MODE_GOLD: a0 = (y0 ^ z0) & (z0 | ~x0);
      MODE_ZERO: a0 = 1'b0;
      default:   a0 = 1'b1;
    endcase
    case (mode1)
      MODE_GOLD: a1 = (y1 ^ z1) & (z1 | ~x1);
      MODE_ZERO: a1 = 1'b0;
      default:   a1 = 1'b1;
    endcase
  end

  truth_table_sequencer #(.HOLD(2), .EXPECT_TT(8'h26)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0),
    .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_map(map0)
  );

  truth_table_sequencer #(.HOLD(1), .EXPECT_TT(8'h26)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_map(map1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // Hand-computed outcomes for EXPECT_TT=8'h26 (ones at vectors 1,2,5)
  function automatic res_t expected_result(int mode, int t0, int hold);
    res_t r;
    r.done_edge = t0 + 1 + 8 * (hold + 1);
    case (mode)
      MODE_GOLD: begin r.pass = 1'b1; r.err = 4'd0; r.map = 8'h00; end
      MODE_ZERO: begin r.pass = 1'b0; r.err = 4'd3; r.map = 8'h26; end
      default:   begin r.pass = 1'b0; r.err = 4'd5; r.map = 8'hD9; end
    endcase
    return r;
  endfunction

  // Monitors
  logic done0_q = 1'b0, done1_q = 1'b0;

  always @(negedge clk) begin
    res_t r;
    if (busy0) begin
      if (xyz_q0.size() == 0) fail_now("xyz0_unexpected_busy");
      else chk("xyz0", {29'd0, x0, y0, z0}, {29'd0, xyz_q0.pop_front()});
    end
    if (done0 && !done0_q) begin
      if (res_q0.size() == 0) fail_now("done0_unexpected");
      else begin
        r = res_q0.pop_front();
        chk("done0_edge", cyc + 1, r.done_edge);
        chk("pass0", {31'd0, pass0}, {31'd0, r.pass});
        chk("err0", {28'd0, err0}, {28'd0, r.err});
        chk("map0", {24'd0, map0}, {24'd0, r.map});
        chk("busy0_at_done", {31'd0, busy0}, 32'd0);
        chk("xyz0_at_done", {29'd0, x0, y0, z0}, 32'd0);
      end
    end
    done0_q = done0;
  end

  always @(negedge clk) begin
    res_t r;
    if (busy1) begin
      if (xyz_q1.size() == 0) fail_now("xyz1_unexpected_busy");
      else chk("xyz1", {29'd0, x1, y1, z1}, {29'd0, xyz_q1.pop_front()});
    end
    if (done1 && !done1_q) begin
      if (res_q1.size() == 0) fail_now("done1_unexpected");
      else begin
        r = res_q1.pop_front();
        chk("done1_edge", cyc + 1, r.done_edge);
        chk("pass1", {31'd0, pass1}, {31'd0, r.pass});
        chk("err1", {28'd0, err1}, {28'd0, r.err});
        chk("map1", {24'd0, map1}, {24'd0, r.map});
      end
    end
    done1_q = done1;
  end

  // Stimulus helpers
  task automatic start_sweep(input int d, input int mode);
    int t0;
    int hold;
    hold = (d == 0) ? 2 : 1;
    @(negedge clk);
    if (d == 0) begin mode0 = mode; start0 = 1'b1; end
    else        begin mode1 = mode; start1 = 1'b1; end
    @(posedge clk);
    #1;
    t0 = cyc;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h <= hold; h++) begin
        if (d == 0) xyz_q0.push_back(3'(v));
        else        xyz_q1.push_back(3'(v));
      end
    end
    if (d == 0) res_q0.push_back(expected_result(mode, t0, hold));
    else        res_q1.push_back(expected_result(mode, t0, hold));
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((d == 0) ? done0 : done1) !== 1'b1 && n < 100);
    if (n >= 100) fail_now((d == 0) ? "timeout_done0" : "timeout_done1");
  endtask

  task automatic wait_vec0(input logic [2:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy0 === 1'b1 && {x0, y0, z0} === v) && n < 100);
    if (n >= 100) fail_now("timeout_vec0");
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_xyz", {29'd0, x0, y0, z0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_pass", {31'd0, pass0}, 32'd0);
    chk("rst_err", {28'd0, err0}, 32'd0);
    chk("rst_map", {24'd0, map0}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden sweep
    start_sweep(0, MODE_GOLD);
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("done_level_held", {31'd0, done0}, 32'd1);

    // a stuck at 0, then at 1
    start_sweep(0, MODE_ZERO);
    wait_done(0);
    start_sweep(0, MODE_ONE);
    wait_done(0);

    // Extra start mid-sweep (at vector 4) must be ignored
    start_sweep(0, MODE_GOLD);
    wait_vec0(3'd4);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0);

    // Restart from DONE clears the previous failing result
    start_sweep(0, MODE_ZERO);
    wait_done(0);
    start_sweep(0, MODE_GOLD);
    chk("restart_done_low", {31'd0, done0}, 32'd0);
    chk("restart_busy", {31'd0, busy0}, 32'd1);
    chk("restart_err_clr", {28'd0, err0}, 32'd0);
    chk("restart_map_clr", {24'd0, map0}, 32'd0);
    wait_done(0);

    // HOLD=1 build
    start_sweep(1, MODE_GOLD);
    wait_done(1);

    // Asynchronous reset between edges during vector 5
    start_sweep(0, MODE_ZERO);
    wait_vec0(3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_xyz", {29'd0, x0, y0, z0}, 32'd0);
    chk("arst_busy", {31'd0, busy0}, 32'd0);
    chk("arst_done", {31'd0, done0}, 32'd0);
    chk("arst_err", {28'd0, err0}, 32'd0);
    chk("arst_map", {24'd0, map0}, 32'd0);
    xyz_q0.delete();
    res_q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy0}, 32'd0);
      chk("idle_done", {31'd0, done0}, 32'd0);
    end

    // Sweep after reset recovery
    start_sweep(0, MODE_ONE);
    wait_done(0);

    @(negedge clk);
    chk("xyz_q0_drained", xyz_q0.size(), 32'd0);
    chk("res_q0_drained", res_q0.size(), 32'd0);
    chk("xyz_q1_drained", xyz_q1.size(), 32'd0);
    chk("res_q1_drained", res_q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Clocked stimulus-and-check stage that sits directly upstream of a 3-input combinational logic block (inputs X,Y,Z; output A).
- Drives all 8 input combinations in ascending order and holds each for a programmable settle time.
- Samples the block's output A for each combination and compares it against a parameterised expected truth table.
- Reports an error count, a per-vector failure bitmap, and pass/done status.

Parameters:
- HOLD, 2: settle cycles each vector is driven before sampling. Legal range 1..15.
- EXPECT_TT, 8'h26: expected A for each input vector; bit n corresponds to n = {X,Y,Z}. The default is A = (Y^Z)&(Z|~X).

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a full sweep
- a  in  1  output A of the downstream logic block
- x  out  1  drives input X of the downstream block
- y  out  1  drives input Y of the downstream block
- z  out  1  drives input Z of the downstream block
- busy  out  1  high while a sweep is in progress
- done  out  1  high (level) once a sweep has completed, until the next accepted start
- pass  out  1  high with done when err_count==0
- err_count  out  4  number of mismatching vectors, 0..8
- fail_map  out  8  bit n set if vector n mismatched

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; x=y=z=0; busy=done=pass=0; err_count=0; fail_map=0; vector index=0; hold counter=0. Reset is effective mid-sweep and abandons the sweep with no partial result.
- States and transitions:
  - IDLE: on start=1, go to DRIVE; clear err_count and fail_map; set vec=0.
  - DRIVE: {x,y,z}=vec. hold_cnt runs 0..HOLD-1. At hold_cnt==HOLD-1, go to SAMPLE.
  - SAMPLE: {x,y,z} still equals vec. Register a and compare it with EXPECT_TT[vec].
    - On mismatch: err_count+=1 and fail_map[vec]=1.
    - If vec==7: go to DONE.
    - Otherwise: vec+=1, hold_cnt=0, go to DRIVE.
  - DONE: done=1, pass=(err_count==0), busy=0; {x,y,z} returns to 0. Results hold until the next start. start=1 re-arms exactly as from IDLE (counters cleared, vec=0, go to DRIVE).
- busy=1 in DRIVE and SAMPLE only. done deasserts in the cycle DRIVE is entered.
- Timing: start is sampled high at edge T0. DRIVE begins at T0+1. Each vector occupies HOLD+1 cycles. done is first high at T0+1+8*(HOLD+1); with HOLD=2 this is T0+25.
- start is ignored while busy=1; no restart and no effect on counters.
- a is sampled only in SAMPLE; glitches during DRIVE are don't-care.
- Widths: vec is 3 bits and never wraps (terminates at 7). err_count saturation is not needed (maximum 8 fits in 4 bits).
- Outputs x,y,z,busy,done,pass,err_count,fail_map are all registered, with no combinational path from a or start.

Test Plan:
- Golden DUT (A=(Y^Z)&(Z|~X)), HOLD=2, one start pulse.
  - x,y,z step through 000..111, each held 3 cycles.
  - done at T0+25 with pass=1, err_count=0, fail_map=8'h00.
- a tied to 0, HOLD=2.
  - err_count=3, fail_map=8'h26, pass=0, done=1.
- a tied to 1.
  - err_count=5, fail_map=8'hD9, pass=0.
- start pulsed again at vector 4 mid-sweep.
  - Ignored: sweep finishes at the original T0+25 with results identical to the single-start run.
  - A start issued in DONE then clears err_count/fail_map and reruns, with done low from the next cycle.
- rst_n driven low asynchronously during vector 5, between clock edges.
  - x=y=z=0, busy=0, done=0, err_count=0, fail_map=0 immediately.
  - After release, IDLE holds until start.
- HOLD=1 build, golden DUT.
  - Each vector held 2 cycles; done at T0+17, pass=1.
